// File: rtl/paddle_ctrl.sv
// Paddle position, speed ramp and power-up radius control for a breakout-style game.
// All visible state advances only on an unpaused frame_tick so the renderer sees whole-frame updates.
module paddle_ctrl #(
  parameter int LEFT  = 160,
  parameter int MAXX  = 320,
  parameter int PD_Y  = 464,
  parameter int R_DEF = 32,
  parameter int R_MIN = 16,
  parameter int R_MAX = 48,
  parameter int V_MAX = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       move_left,
  input  logic       move_right,
  input  logic       grow_req,
  input  logic       shrink_req,
  input  logic       pause,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic [5:0] radius,
  output logic [1:0] at_wall
);

  localparam int SW = $clog2(V_MAX + 1);

  typedef enum logic [1:0] {STILL = 2'd0, MOVE_L = 2'd1, MOVE_R = 2'd2} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [SW-1:0]        r_speed;
  logic [SW-1:0]        w_speed_nxt;
  logic [SW-1:0]        w_speed_use;
  logic [1:0]           r_cnt;
  logic [1:0]           w_cnt_nxt;
  logic [5:0]           r_target;
  logic [5:0]           w_target_nxt;
  logic [6:0]           w_grow;
  logic [5:0]           r_radius;
  logic [5:0]           w_rad_nxt;
  logic [9:0]           r_x;
  logic [9:0]           r_y;
  logic [1:0]           r_wall;
  logic signed [10:0]   w_x_ext;
  logic signed [10:0]   w_spd_ext;
  logic signed [10:0]   w_x_step;
  logic signed [10:0]   w_lo;
  logic signed [10:0]   w_hi;
  logic [9:0]           w_x_clamp;
  logic [1:0]           w_wall_nxt;
  logic                 w_tick;

  assign w_tick  = frame_tick & ~pause;
  assign x       = r_x;
  assign y       = r_y;
  assign radius  = r_radius;
  assign at_wall = r_wall;

  // Direction select plus speed ramp; a new direction always restarts at speed 1.
  always_comb begin
    w_state_nxt = STILL;
    w_speed_use = SW'(1);
    w_speed_nxt = SW'(1);
    w_cnt_nxt   = 2'd0;
    if (move_left && !move_right) begin
      w_state_nxt = MOVE_L;
    end else if (move_right && !move_left) begin
      w_state_nxt = MOVE_R;
    end else begin
      w_state_nxt = STILL;
    end
    if (w_state_nxt == STILL) begin
      w_speed_nxt = SW'(1);
      w_cnt_nxt   = 2'd0;
    end else if (w_state_nxt != r_state) begin
      w_speed_nxt = SW'(1);
      w_cnt_nxt   = 2'd1;
    end else begin
      w_speed_use = r_speed;
      if (r_cnt == 2'd3) begin
        w_cnt_nxt   = 2'd0;
        w_speed_nxt = (r_speed == SW'(V_MAX)) ? r_speed : r_speed + SW'(1);
      end else begin
        w_cnt_nxt   = r_cnt + 2'd1;
        w_speed_nxt = r_speed;
      end
    end
  end

  // Radius step, position step and clamp against walls computed with the new radius.
  always_comb begin
    w_rad_nxt = r_radius;
    if (r_target > r_radius) begin
      w_rad_nxt = r_radius + 6'd1;
    end else if (r_target < r_radius) begin
      w_rad_nxt = r_radius - 6'd1;
    end else begin
      w_rad_nxt = r_radius;
    end
    w_x_ext  = {1'b0, r_x};
    w_spd_ext = 11'(w_speed_use);
    case (w_state_nxt)
      MOVE_L:  w_x_step = w_x_ext - w_spd_ext;
      MOVE_R:  w_x_step = w_x_ext + w_spd_ext;
      default: w_x_step = w_x_ext;
    endcase
    w_lo = 11'(LEFT) + 11'(w_rad_nxt);
    w_hi = 11'(LEFT + MAXX) - 11'(w_rad_nxt);
    if (w_x_step < w_lo) begin
      w_x_clamp = w_lo[9:0];
    end else if (w_x_step > w_hi) begin
      w_x_clamp = w_hi[9:0];
    end else begin
      w_x_clamp = w_x_step[9:0];
    end
    w_wall_nxt = {(11'(w_x_clamp) == w_hi), (11'(w_x_clamp) == w_lo)};
  end

  // Power-up requests retarget immediately, even while paused; simultaneous requests cancel.
  always_comb begin
    w_grow       = {1'b0, r_target} + 7'd8;
    w_target_nxt = r_target;
    if (grow_req && !shrink_req) begin
      w_target_nxt = (w_grow > 7'(R_MAX)) ? 6'(R_MAX) : w_grow[5:0];
    end else if (shrink_req && !grow_req) begin
      w_target_nxt = (r_target < 6'(R_MIN + 8)) ? 6'(R_MIN) : r_target - 6'd8;
    end else begin
      w_target_nxt = r_target;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= STILL;
    end else if (w_tick) begin
      r_state <= w_state_nxt;
    end else begin
      r_state <= r_state;
    end
  end

  // Datapath registers; reset wins over ticks and radius requests.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x      <= 10'(LEFT + MAXX / 2);
      r_y      <= 10'(PD_Y);
      r_radius <= 6'(R_DEF);
      r_target <= 6'(R_DEF);
      r_speed  <= SW'(1);
      r_cnt    <= 2'd0;
      r_wall   <= 2'b00;
    end else begin
      r_y      <= 10'(PD_Y);
      r_target <= w_target_nxt;
      if (w_tick) begin
        r_x      <= w_x_clamp;
        r_radius <= w_rad_nxt;
        r_speed  <= w_speed_nxt;
        r_cnt    <= w_cnt_nxt;
        r_wall   <= w_wall_nxt;
      end
    end
  end

endmodule
